// File: rtl/cdc_toggle_rx.sv
// cdc_toggle_rx: receives two-phase toggle CDC events and presents them with a valid/ready handshake.
module cdc_toggle_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_toggle_in,
  output logic             ack_toggle_out,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [CNT_W-1:0] evt_count,
  output logic             err_sticky,
  input  logic             err_clr
);
  typedef enum logic {IDLE, VALID} state_t;
  state_t                 r_state;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_ack;
  logic                   r_valid;
  logic [CNT_W-1:0]       r_count;
  logic                   r_err;
  logic                   w_sync_req;
  logic                   w_accept;
  logic                   w_violation;
  assign w_sync_req = r_sync[SYNC_STAGES-1];
  assign w_accept = (r_state == VALID) && evt_ready;
  // Source toggled again before our ack: the pending event absorbs the extra toggle.
  assign w_violation = (r_state == VALID) && (w_sync_req == r_ack);
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync  <= '0;
      r_state <= IDLE;
      r_ack   <= 1'b0;
      r_valid <= 1'b0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], req_toggle_in};
      r_err  <= w_violation ? 1'b1 : err_clr ? 1'b0 : r_err;
      if (r_state == IDLE) begin
        if (w_sync_req != r_ack) begin
          r_state <= VALID;
          r_valid <= 1'b1;
        end
      end else if (w_accept) begin
        r_state <= IDLE;
        r_valid <= 1'b0;
        r_ack   <= w_sync_req;
        r_count <= r_count + 1'b1;
      end
    end
  end
  assign ack_toggle_out = r_ack;
  assign evt_valid      = r_valid;
  assign evt_count      = r_count;
  assign err_sticky     = r_err;
endmodule
